ahb_lite_slave: RTL and testbench
=================================

// Module: ahb_lite_slave
// PURPOSE
// AHB-Lite slave that services host reads/writes of the USB endpoint register map: it reads the
// captured statusData/errorData/boData/ehtsData values, drives nextEHTSData, issues data-buffer
// strobes, and holds the TX packet control and flush registers. Sits between the AHB fabric and
// value_registers/data buffer; all host visibility of the USB side goes through this block.
// PARAMETERS
// ADDR_W   4   HADDR bits decoded (map spans 0x0-0xF)
// DATA_W   32  HWDATA/HRDATA width; little-endian byte lanes, lane = addr[1:0]
// PORTS
// clk            in   1   system clock
// nRst           in   1   asynchronous active-low reset
// hsel           in   1   slave select
// haddr          in   4   address (address phase)
// htrans         in   2   0 IDLE,1 BUSY,2 NONSEQ,3 SEQ; transfer valid when hsel & htrans[1]
// hsize          in   2   0 byte,1 half,2 word
// hwrite         in   1   1 = write
// hwdata         in   32  write data (data phase)
// hrdata         out  32  read data (data phase)
// hready         out  1   0 inserts wait state
// hresp          out  1   1 = ERROR response
// statusData     in   16  {8'b0,.., txTransferActive, rxTransferActive, rxDataReady} status
// errorData      in   16  {txError byte, rxError byte}
// boData         in   8   buffer occupancy (bytes)
// ehtsData       in   8   current EHTS register value
// nextEHTSData   out  8   EHTS value for value_registers to capture next cycle
// rxData         in   32  data buffer read data, valid one cycle after getRxData
// getRxData      out  1   1-cycle buffer read strobe
// storeTxData    out  1   1-cycle buffer write strobe
// txData         out  32  buffer write data (=hwdata, lane-aligned)
// dataSize       out  2   bytes-1 for buffer strobe (0..3)
// txPacket       out  3   TX packet control register
// txDone         in   1   pulse: TX packet sent, clears txPacket
// flush          out  1   buffer flush request
// BEHAVIOUR
// Reset: hrdata=0, hready=1, hresp=0, strobes=0, txPacket=0, flush=0, nextEHTSData=0, FSM=IDLE.
// Map: 0x0-0x3 data buffer R/W | 0x4-0x5 status R | 0x6-0x7 error R | 0x8 boData R |
//      0xC txPacket R/W | 0xD flush R/W (bit0) | 0xE EHTS R/W | 0x9-0xB,0xF unmapped.
// Address phase (hready=1 & valid) latches haddr/hsize/hwrite; next cycle is data phase.
// FSM: IDLE -> DATA on valid mapped access; -> ERR1 on write to RO, unmapped addr, or
//   access crossing word boundary (addr[1:0]+size bytes > 4); DATA -> WAIT for buffer read.
// DATA: reads: hrdata combinational from latched addr, register byte on lane addr[1:0]
//   (word @0x4 = {errorData,statusData}); hready=1. Writes take effect at end of data phase.
// WAIT (buffer read): getRxData pulses in address->data transition, hready=0 one cycle,
//   hrdata=rxData on next cycle with hready=1 => reads of 0x0-0x3 cost 1 wait state.
// Buffer write: storeTxData=1 during data phase with txData=hwdata, dataSize=size; 0 wait.
// ERR1: hready=0,hresp=1; ERR2: hready=1,hresp=1; then IDLE (or accept pipelined addr).
//   Erroring writes change no state; erroring reads return hrdata=0.
// nextEHTSData = ehtsData every cycle, except = hwdata lane byte in the EHTS write data phase.
// txPacket: written value; txDone same cycle as write -> write wins; else txDone clears to 0.
// flush: write bit0=1 sets; clears when boData==0 (checked from cycle after set); reads flush.
// BUSY/IDLE htrans or hsel=0 -> hready=1, hresp=0, no strobes. Async reset mid-transfer
//   aborts it, outputs to reset values immediately.
// TESTING
// 1 reset -> hready=1,hresp=0,hrdata=0,txPacket=0,flush=0,nextEHTSData=0.
// 2 statusData=16'h0201,errorData=16'h0101: word read 0x4 -> hrdata=32'h0101_0201, 0 wait;
//   byte read 0x7 -> hrdata[31:24]=8'h01.
// 3 byte write 0xE hwdata[23:16]=8'h3A -> nextEHTSData=8'h3A that data phase; read 0xE later
//   (ehtsData=8'h3A) -> hrdata[23:16]=8'h3A.
// 4 write 0x4 or read 0x9 -> ERR1 then ERR2 (hready 0 then 1, hresp=1 both), no state change.
// 5 word read 0x0, rxData=32'hDEADBEEF -> getRxData 1 cycle, 1 wait, hrdata=32'hDEADBEEF;
//   half write 0x0 -> storeTxData 1 cycle, dataSize=1, no wait.
// 6 write 0xC=2 -> txPacket=2; txDone -> 0; write 0xD=1 with boData=8'h12 -> flush stays 1
//   until boData=0, then 0.

Source files
------------

// File: rtl/ahb_lite_slave.sv
// AHB-Lite slave exposing the USB endpoint register map (status, error, occupancy,
// EHTS, TX packet control, flush) and strobing the data buffer for 0x0-0x3 accesses.
module ahb_lite_slave #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic [1:0]        hsize,
   input  logic              hwrite,
   input  logic [DATA_W-1:0] hwdata,
   output logic [DATA_W-1:0] hrdata,
   output logic              hready,
   output logic              hresp,
   input  logic [15:0]       statusData,
   input  logic [15:0]       errorData,
   input  logic [7:0]        boData,
   input  logic [7:0]        ehtsData,
   output logic [7:0]        nextEHTSData,
   input  logic [DATA_W-1:0] rxData,
   output logic              getRxData,
   output logic              storeTxData,
   output logic [DATA_W-1:0] txData,
   output logic [1:0]        dataSize,
   output logic [2:0]        txPacket,
   input  logic              txDone,
   output logic              flush
);

   typedef enum logic [2:0] {IDLE, DATA, WAIT, ERR1, ERR2} stateType;

   stateType          state;
   logic [ADDR_W-1:0] aAddr;
   logic [1:0]        aSize;
   logic              aWrite;

   logic       accept;
   logic [3:0] spanEnd;
   logic       addrErr;
   logic       bufAccess;
   logic [3:0] laneMask;
   logic [3:0] laneEn;
   logic       ctrlWrite;
   logic       wrTx;
   logic       wrFlush;
   logic       wrEhts;
   logic       unusedBits;

   assign unusedBits = htrans[0];
   assign accept     = hready & hsel & htrans[1];

   // Address-phase decode: unmapped, read-only or word-crossing accesses error out
   always_comb begin
      spanEnd   = {2'b00, haddr[1:0]} + (4'd1 << hsize);
      bufAccess = (haddr[3:2] == 2'b00);
      addrErr   = (spanEnd > 4'd4)
                | (haddr inside {4'h9, 4'hA, 4'hB, 4'hF})
                | (hwrite & (haddr inside {[4'h4:4'h8]}));
   end

   // Byte lanes touched by the transfer currently in its data phase
   always_comb begin
      case (aSize)
         2'd0:    laneMask = 4'b0001;
         2'd1:    laneMask = 4'b0011;
         default: laneMask = 4'b1111;
      endcase
      laneEn    = 4'(laneMask << aAddr[1:0]);
      ctrlWrite = (state == DATA) & aWrite & (aAddr[3:2] == 2'b11);
      wrTx      = ctrlWrite & laneEn[0];
      wrFlush   = ctrlWrite & laneEn[1];
      wrEhts    = ctrlWrite & laneEn[2];
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state       <= IDLE;
         hready      <= 1'b1;
         hresp       <= 1'b0;
         aAddr       <= '0;
         aSize       <= 2'd0;
         aWrite      <= 1'b0;
         getRxData   <= 1'b0;
         storeTxData <= 1'b0;
         dataSize    <= 2'd0;
      end else begin
         getRxData   <= 1'b0;
         storeTxData <= 1'b0;
         if (accept) begin
            aAddr    <= haddr;
            aSize    <= hsize;
            aWrite   <= hwrite;
            dataSize <= (hsize == 2'd2) ? 2'd3 : hsize;
            if (addrErr) begin
               state  <= ERR1;
               hready <= 1'b0;
               hresp  <= 1'b1;
            end else if (bufAccess && !hwrite) begin
               state     <= WAIT;
               hready    <= 1'b0;
               hresp     <= 1'b0;
               getRxData <= 1'b1;
            end else begin
               state       <= DATA;
               hready      <= 1'b1;
               hresp       <= 1'b0;
               storeTxData <= bufAccess & hwrite;
            end
         end else begin
            case (state)
               WAIT: begin
                  state  <= DATA;
                  hready <= 1'b1;
                  hresp  <= 1'b0;
               end
               ERR1: begin
                  state  <= ERR2;
                  hready <= 1'b1;
                  hresp  <= 1'b1;
               end
               default: begin
                  state  <= IDLE;
                  hready <= 1'b1;
                  hresp  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Control registers; a host write to txPacket beats a coincident txDone
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         txPacket <= 3'd0;
         flush    <= 1'b0;
      end else begin
         if (wrTx)
            txPacket <= hwdata[2:0];
         else if (txDone)
            txPacket <= 3'd0;
         if (wrFlush && hwdata[8])
            flush <= 1'b1;
         else if (flush && boData == 8'd0)
            flush <= 1'b0;
      end
   end

   // Read data follows the latched address; buffer reads land after the wait state
   always_comb begin
      hrdata = '0;
      if (state == DATA && !aWrite) begin
         case (aAddr[3:2])
            2'b00:   hrdata = rxData;
            2'b01:   hrdata = {errorData, statusData};
            2'b10:   hrdata = {24'h0, boData};
            default: hrdata = {8'h0, ehtsData, 7'h0, flush, 5'h0, txPacket};
         endcase
      end
   end

   assign txData       = hwdata;
   assign nextEHTSData = !nRst ? 8'h00 : (wrEhts ? hwdata[23:16] : ehtsData);

endmodule

// File: tb/tb_ahb_lite_slave.sv
// Directed bench for ahb_lite_slave: register reads/writes, error responses,
// buffer strobes, txPacket/flush behaviour and asynchronous reset.
module tb_ahb_lite_slave;

   logic        tb_clk = 1'b0;
   logic        nRst;
   logic        hsel;
   logic [3:0]  haddr;
   logic [1:0]  htrans;
   logic [1:0]  hsize;
   logic        hwrite;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;
   logic [15:0] statusData;
   logic [15:0] errorData;
   logic [7:0]  boData;
   logic [7:0]  ehtsData;
   logic [7:0]  nextEHTSData;
   logic [31:0] rxData;
   logic        getRxData;
   logic        storeTxData;
   logic [31:0] txData;
   logic [1:0]  dataSize;
   logic [2:0]  txPacket;
   logic        txDone;
   logic        flush;

   int checks   = 0;
   int failures = 0;

   always #5 tb_clk = ~tb_clk;

   ahb_lite_slave dut (
      .clk(tb_clk), .nRst(nRst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
      .hready(hready), .hresp(hresp), .statusData(statusData), .errorData(errorData),
      .boData(boData), .ehtsData(ehtsData), .nextEHTSData(nextEHTSData),
      .rxData(rxData), .getRxData(getRxData), .storeTxData(storeTxData),
      .txData(txData), .dataSize(dataSize), .txPacket(txPacket), .txDone(txDone),
      .flush(flush)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   // Drive one address phase, then release the bus so the following cycle is its data phase
   task automatic addrPhase(input logic [3:0] a, input logic [1:0] sz, input logic wr);
      hsel   = 1'b1;
      haddr  = a;
      htrans = 2'd2;
      hsize  = sz;
      hwrite = wr;
      tick();
      hsel   = 1'b0;
      htrans = 2'd0;
      hwrite = 1'b0;
   endtask

   initial begin
      nRst = 1'b0; hsel = 1'b0; haddr = 4'h0; htrans = 2'd0; hsize = 2'd0;
      hwrite = 1'b0; hwdata = 32'h0; statusData = 16'h0; errorData = 16'h0;
      boData = 8'h0; ehtsData = 8'h55; rxData = 32'h0; txDone = 1'b0;

      #12;
      checkVal("rst_hready", 32'(hready), 32'd1);
      checkVal("rst_hresp", 32'(hresp), 32'd0);
      checkVal("rst_hrdata", hrdata, 32'h0);
      checkVal("rst_txPacket", 32'(txPacket), 32'd0);
      checkVal("rst_flush", 32'(flush), 32'd0);
      checkVal("rst_nextEHTS", 32'(nextEHTSData), 32'h0);
      checkVal("rst_strobes", 32'({getRxData, storeTxData}), 32'd0);
      tick();
      nRst = 1'b1;
      tick();
      checkVal("idle_nextEHTS", 32'(nextEHTSData), 32'h55);
      ehtsData = 8'h00;

      // status/error reads
      statusData = 16'h0201;
      errorData  = 16'h0101;
      addrPhase(4'h4, 2'd2, 1'b0);
      #1;
      checkVal("rd04_data", hrdata, 32'h0101_0201);
      checkVal("rd04_hready", 32'(hready), 32'd1);
      checkVal("rd04_hresp", 32'(hresp), 32'd0);
      tick();
      addrPhase(4'h7, 2'd0, 1'b0);
      #1;
      checkVal("rd07_byte", 32'(hrdata[31:24]), 32'h01);
      checkVal("rd07_hready", 32'(hready), 32'd1);
      tick();
      boData = 8'h12;
      addrPhase(4'h8, 2'd0, 1'b0);
      #1;
      checkVal("rd08_bo", 32'(hrdata[7:0]), 32'h12);
      tick();

      // EHTS write and read back
      addrPhase(4'hE, 2'd0, 1'b1);
      hwdata = 32'h003A_0000;
      #1;
      checkVal("wr0E_next", 32'(nextEHTSData), 32'h3A);
      tick();
      ehtsData = 8'h3A;
      hwdata = 32'h0;
      #1;
      checkVal("after0E_next", 32'(nextEHTSData), 32'h3A);
      addrPhase(4'hE, 2'd0, 1'b0);
      #1;
      checkVal("rd0E_byte", 32'(hrdata[23:16]), 32'h3A);
      tick();

      // error responses
      addrPhase(4'h4, 2'd2, 1'b1);
      hwdata = 32'hFFFF_FFFF;
      #1;
      checkVal("wr04_err1", 32'({hready, hresp}), 32'b01);
      tick();
      checkVal("wr04_err2", 32'({hready, hresp}), 32'b11);
      checkVal("wr04_hrdata", hrdata, 32'h0);
      tick();
      checkVal("wr04_done", 32'({hready, hresp}), 32'b10);
      addrPhase(4'h9, 2'd0, 1'b0);
      #1;
      checkVal("rd09_err1", 32'({hready, hresp}), 32'b01);
      checkVal("rd09_hrdata", hrdata, 32'h0);
      tick();
      checkVal("rd09_err2", 32'({hready, hresp}), 32'b11);
      tick();
      addrPhase(4'h3, 2'd1, 1'b0);
      #1;
      checkVal("rd03_cross", 32'({hready, hresp}), 32'b01);
      checkVal("rd03_noStrobe", 32'(getRxData), 32'd0);
      tick();
      tick();
      addrPhase(4'hE, 2'd2, 1'b1);
      hwdata = 32'h0077_0000;
      #1;
      checkVal("wr0E_cross", 32'({hready, hresp}), 32'b01);
      checkVal("wr0E_crossNext", 32'(nextEHTSData), 32'h3A);
      tick();
      tick();
      checkVal("err_noState", 32'({txPacket, flush}), 32'd0);

      // data buffer read and write
      rxData = 32'hDEAD_BEEF;
      addrPhase(4'h0, 2'd2, 1'b0);
      #1;
      checkVal("rdBuf_wait", 32'({hready, getRxData}), 32'b01);
      tick();
      checkVal("rdBuf_data", hrdata, 32'hDEAD_BEEF);
      checkVal("rdBuf_ready", 32'({hready, getRxData}), 32'b10);
      tick();
      addrPhase(4'h0, 2'd1, 1'b1);
      hwdata = 32'h0000_CAFE;
      #1;
      checkVal("wrBuf_strobe", 32'({hready, storeTxData}), 32'b11);
      checkVal("wrBuf_size", 32'(dataSize), 32'd1);
      checkVal("wrBuf_txData", txData, 32'h0000_CAFE);
      tick();
      checkVal("wrBuf_pulse", 32'(storeTxData), 32'd0);

      // txPacket
      addrPhase(4'hC, 2'd0, 1'b1);
      hwdata = 32'h0000_0002;
      tick();
      checkVal("txPacket_wr", 32'(txPacket), 32'd2);
      txDone = 1'b1;
      tick();
      txDone = 1'b0;
      checkVal("txPacket_done", 32'(txPacket), 32'd0);
      addrPhase(4'hC, 2'd0, 1'b1);
      hwdata = 32'h0000_0005;
      txDone = 1'b1;
      tick();
      txDone = 1'b0;
      checkVal("txPacket_wins", 32'(txPacket), 32'd5);

      // flush holds until the buffer drains
      boData = 8'h12;
      addrPhase(4'hD, 2'd0, 1'b1);
      hwdata = 32'h0000_0100;
      tick();
      checkVal("flush_set", 32'(flush), 32'd1);
      hwdata = 32'h0;
      tick();
      checkVal("flush_hold", 32'(flush), 32'd1);
      addrPhase(4'hD, 2'd0, 1'b0);
      #1;
      checkVal("flush_read", 32'(hrdata[8]), 32'd1);
      tick();
      boData = 8'h00;
      #1;
      checkVal("flush_beforeDrain", 32'(flush), 32'd1);
      tick();
      checkVal("flush_cleared", 32'(flush), 32'd0);

      // asynchronous reset in the middle of a buffer read
      addrPhase(4'h0, 2'd2, 1'b0);
      #1;
      checkVal("arst_pre", 32'(hready), 32'd0);
      nRst = 1'b0;
      #1;
      checkVal("arst_outs", 32'({hready, hresp, getRxData}), 32'b100);
      checkVal("arst_txPacket", 32'(txPacket), 32'd0);
      tick();
      nRst = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
